hbus_wrreg_stm: RTL and testbench

//  Sub-state-machine for HyperRAM configuration-register writes (CR0/CR1). Driven by the top-level

---
 rtl/hbus_wrreg_stm.sv | 158 +++++++++++++++
 tb/tb_hbus_wrreg_stm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hbus_wrreg_stm.sv
// HyperBus configuration-register write sub-state-machine.
// Zero-latency CR write: CS# setup, 3 CA words, 1 data word, CS# hold, recovery.
module hbus_wrreg_stm #(
    parameter int CSS_CYCLES  = 1,
    parameter int CSH_CYCLES  = 1,
    parameter int CSHI_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stm_start,
    input  logic [47:0] i_casig,
    input  logic [15:0] i_wrdata,
    output logic        o_stm_end,
    output logic        o_oe,
    output logic        o_oe_clk,
    output logic        o_csn,
    output logic [15:0] o_datain,
    output logic        o_busy,
    output logic [7:0]  o_wr_count
);

    localparam int MAXP0 = (CSS_CYCLES > CSH_CYCLES) ? CSS_CYCLES : CSH_CYCLES;
    localparam int MAXP  = (MAXP0 > CSHI_CYCLES) ? MAXP0 : CSHI_CYCLES;
    localparam int CW    = (MAXP < 2) ? 1 : $clog2(MAXP + 1);

    // bit 47 = R/W# (0 = write), bit 46 = register space
    localparam logic [47:0] CA_RW_BIT  = 48'h8000_0000_0000;
    localparam logic [47:0] CA_REG_BIT = 48'h4000_0000_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_CSS, S_CA0, S_CA1, S_CA2,
        S_DATA, S_CSH, S_RECOV, S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [47:0]   r_ca;
    logic [15:0]   r_wd;
    logic          r_abort;
    logic          r_stm_end;
    logic          r_oe;
    logic          r_oe_clk;
    logic          r_csn;
    logic [15:0]   r_datain;
    logic          r_busy;
    logic [7:0]    r_wr_count;

    logic w_active;
    assign w_active = (r_state == S_CSS) || (r_state == S_CA0) ||
                      (r_state == S_CA1) || (r_state == S_CA2) ||
                      (r_state == S_DATA) || (r_state == S_CSH);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ca       <= '0;
            r_wd       <= '0;
            r_abort    <= 1'b0;
            r_stm_end  <= 1'b0;
            r_oe       <= 1'b0;
            r_oe_clk   <= 1'b0;
            r_csn      <= 1'b1;
            r_datain   <= '0;
            r_busy     <= 1'b0;
            r_wr_count <= '0;
        end else if (w_active && !i_stm_start) begin
            r_state  <= S_RECOV;
            r_cnt    <= CW'(CSHI_CYCLES - 1);
            r_abort  <= 1'b1;
            r_csn    <= 1'b1;
            r_oe     <= 1'b0;
            r_oe_clk <= 1'b0;
            r_datain <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_stm_start) begin
                        r_ca    <= (i_casig & ~CA_RW_BIT) | CA_REG_BIT;
                        r_wd    <= i_wrdata;
                        r_abort <= 1'b0;
                        r_cnt   <= CW'(CSS_CYCLES - 1);
                        r_csn   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CSS;
                    end
                end
                S_CSS: begin
                    if (r_cnt == '0) begin
                        r_oe     <= 1'b1;
                        r_oe_clk <= 1'b1;
                        r_datain <= r_ca[47:32];
                        r_state  <= S_CA0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CA0: begin
                    r_datain <= r_ca[31:16];
                    r_state  <= S_CA1;
                end
                S_CA1: begin
                    r_datain <= r_ca[15:0];
                    r_state  <= S_CA2;
                end
                S_CA2: begin
                    r_datain <= r_wd;
                    r_state  <= S_DATA;
                end
                S_DATA: begin
                    r_oe     <= 1'b0;
                    r_oe_clk <= 1'b0;
                    r_datain <= '0;
                    r_cnt    <= CW'(CSH_CYCLES - 1);
                    r_state  <= S_CSH;
                end
                S_CSH: begin
                    if (r_cnt == '0) begin
                        r_csn   <= 1'b1;
                        r_cnt   <= CW'(CSHI_CYCLES - 1);
                        r_state <= S_RECOV;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RECOV: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_stm_end  <= 1'b1;
                        r_wr_count <= r_wr_count + 8'd1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!i_stm_start) begin
                        r_stm_end <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stm_end  = r_stm_end;
    assign o_oe       = r_oe;
    assign o_oe_clk   = r_oe_clk;
    assign o_csn      = r_csn;
    assign o_datain   = r_datain;
    assign o_busy     = r_busy;
    assign o_wr_count = r_wr_count;

endmodule

// File: tb/tb_hbus_wrreg_stm.sv
// Bench for hbus_wrreg_stm: default and stretched-timing instances
// checked cycle by cycle against a timeline model.
module tb_hbus_wrreg_stm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        sel;
    logic [47:0] ca;
    logic [15:0] wd;

    logic sa, sb;
    assign sa = start & ~sel;
    assign sb = start & sel;

    logic        a_end, a_oe, a_oeclk, a_csn, a_busy;
    logic [15:0] a_din;
    logic [7:0]  a_cnt;
    logic        b_end, b_oe, b_oeclk, b_csn, b_busy;
    logic [15:0] b_din;
    logic [7:0]  b_cnt;

    hbus_wrreg_stm dut_a (
        .i_clk(clk), .i_rst(rst), .i_stm_start(sa),
        .i_casig(ca), .i_wrdata(wd),
        .o_stm_end(a_end), .o_oe(a_oe), .o_oe_clk(a_oeclk),
        .o_csn(a_csn), .o_datain(a_din), .o_busy(a_busy),
        .o_wr_count(a_cnt)
    );

    hbus_wrreg_stm #(
        .CSS_CYCLES(3), .CSH_CYCLES(2), .CSHI_CYCLES(4)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_stm_start(sb),
        .i_casig(ca), .i_wrdata(wd),
        .o_stm_end(b_end), .o_oe(b_oe), .o_oe_clk(b_oeclk),
        .o_csn(b_csn), .o_datain(b_din), .o_busy(b_busy),
        .o_wr_count(b_cnt)
    );

    logic        g_end, g_oe, g_oeclk, g_csn, g_busy;
    logic [15:0] g_din;
    logic [7:0]  g_cnt;
    assign g_end   = sel ? b_end   : a_end;
    assign g_oe    = sel ? b_oe    : a_oe;
    assign g_oeclk = sel ? b_oeclk : a_oeclk;
    assign g_csn   = sel ? b_csn   : a_csn;
    assign g_busy  = sel ? b_busy  : a_busy;
    assign g_din   = sel ? b_din   : a_din;
    assign g_cnt   = sel ? b_cnt   : a_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int p_css, p_csh, p_cshi;
    logic [7:0] m_cnt [2];

    task automatic chk(input string tag, input logic [47:0] got,
                       input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic use_dut(input logic s);
        sel = s;
        if (s) begin
            p_css = 3; p_csh = 2; p_cshi = 4;
        end else begin
            p_css = 1; p_csh = 1; p_cshi = 2;
        end
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " end"}, 48'(g_end), 48'd0);
        chk({tag, " oe"}, 48'(g_oe), 48'd0);
        chk({tag, " oeclk"}, 48'(g_oeclk), 48'd0);
        chk({tag, " csn"}, 48'(g_csn), 48'd1);
        chk({tag, " din"}, 48'(g_din), 48'd0);
        chk({tag, " busy"}, 48'(g_busy), 48'd0);
        chk({tag, " cnt"}, 48'(g_cnt), 48'd0);
    endtask

    // Expected outputs k cycles after the request is sampled.
    // ab < 0: no abort; otherwise stm_start is low from cycle ab.
    task automatic chk_cycle(input int k, input int ab, input int hold,
                             input logic [47:0] caf, input logic [15:0] w);
        int L, E, busy_last, idx;
        logic live;
        logic [15:0] words [4];
        logic e_csn, e_oe, e_end, e_busy;
        logic [15:0] e_din;
        logic [7:0]  e_cnt;
        string t;
        L = p_css + 4 + p_csh;
        E = L + p_cshi + 1;
        idx = sel ? 1 : 0;
        words[0] = caf[47:32];
        words[1] = caf[31:16];
        words[2] = caf[15:0];
        words[3] = w;
        live = (ab < 0) || (k <= ab);
        e_csn = !(live && k >= 1 && k <= L);
        e_oe = live && k >= p_css + 1 && k <= p_css + 4;
        e_din = e_oe ? words[k - p_css - 1] : 16'h0;
        e_end = (ab < 0) && k >= E && k <= E + hold;
        busy_last = (ab < 0) ? E + hold : ab + p_cshi;
        e_busy = k >= 1 && k <= busy_last;
        e_cnt = (ab < 0 && k >= E) ? m_cnt[idx] + 8'd1 : m_cnt[idx];
        t = $sformatf("d%0d k%0d", idx, k);
        chk({t, " csn"}, 48'(g_csn), 48'(e_csn));
        chk({t, " oe"}, 48'(g_oe), 48'(e_oe));
        chk({t, " oeclk"}, 48'(g_oeclk), 48'(e_oe));
        chk({t, " din"}, 48'(g_din), 48'(e_din));
        chk({t, " end"}, 48'(g_end), 48'(e_end));
        chk({t, " busy"}, 48'(g_busy), 48'(e_busy));
        chk({t, " cnt"}, 48'(g_cnt), 48'(e_cnt));
    endtask

    task automatic run_txn(input logic [47:0] c, input logic [15:0] w,
                           input int ab, input int hold);
        logic [47:0] caf;
        int L, E, stop, idx;
        caf = (c & ~(48'h1 << 47)) | (48'h1 << 46);
        L = p_css + 4 + p_csh;
        E = L + p_cshi + 1;
        stop = (ab < 0) ? E + hold + 1 : ab + p_cshi + 1;
        idx = sel ? 1 : 0;
        @(posedge clk); #1;
        ca = c; wd = w; start = 1'b1;
        @(negedge clk);
        chk_cycle(0, ab, hold, caf, w);
        for (int k = 1; k <= stop; k++) begin
            @(posedge clk); #1;
            if (ab == k) start = 1'b0;
            if (ab < 0 && k == E + hold) start = 1'b0;
            if (ab < 0 && k >= E) begin
                ca = {16'($urandom), 32'($urandom)};
                wd = 16'($urandom);
            end
            @(negedge clk);
            chk_cycle(k, ab, hold, caf, w);
        end
        if (ab < 0) m_cnt[idx] = m_cnt[idx] + 8'd1;
    endtask

    task automatic rand_txn(input int abort_pct);
        int ab;
        ab = -1;
        if ($urandom_range(99, 0) < abort_pct)
            ab = $urandom_range(p_css + 4 + p_csh, 1);
        run_txn({16'($urandom), 32'($urandom)}, 16'($urandom), ab,
                $urandom_range(3, 1));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ca = '0; wd = '0;
        m_cnt[0] = 8'd0; m_cnt[1] = 8'd0;
        use_dut(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rstA");
        use_dut(1'b1);
        chk_reset_vals("rstB");
        use_dut(1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn(48'h6000_0100_0000, 16'h8F1F, -1, 1);
        run_txn(48'hC000_0100_0001, 16'h1234, -1, 1);
        run_txn(48'h6000_0100_0000, 16'hA5A5, 3, 1);

        // reset in the middle of a transaction
        @(posedge clk); #1;
        ca = 48'h6000_0100_0002; wd = 16'h5A5A; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 4) rst = 1'b1;
            if (k == 5) begin
                rst = 1'b0;
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk_reset_vals("midrst");
        m_cnt[0] = 8'd0; m_cnt[1] = 8'd0;
        run_txn(48'h6000_0100_0000, 16'h0F0F, -1, 1);

        repeat (40) rand_txn(25);

        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        m_cnt[0] = 8'd0; m_cnt[1] = 8'd0;
        repeat (256) begin
            run_txn({16'($urandom), 32'($urandom)}, 16'($urandom), -1, 1);
        end
        chk("wrap", 48'(g_cnt), 48'd0);

        use_dut(1'b1);
        run_txn(48'h6000_0100_0000, 16'h8F1F, -1, 5);
        repeat (15) rand_txn(30);
        use_dut(1'b0);
        repeat (10) rand_txn(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
